// File: rtl/riscv_pkg.sv
// Shared RV32I core definitions used by the fetch stage.
package riscv_pkg;

    localparam int unsigned XLEN = 32;

    typedef logic [XLEN-1:0] word_t;

    // addi x0, x0, 0
    localparam word_t NOP_INSTR = 32'h0000_0013;

    // Fetch FSM: IDLE = nothing in flight, WAIT = response will be kept,
    // DISCARD = response will be dropped (fetch was redirected meanwhile).
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } fetch_state_e;

    // One buffered fetch result.
    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

    // Contents presented to decode when the buffer is empty.
    localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, instr: NOP_INSTR};

    // Force a byte address onto a word boundary.
    function automatic word_t word_align(input word_t addr);
        return addr & ~word_t'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instr} buffer between instruction memory and decode.
// Slot 0 is always the head, so the head outputs come straight from a register.
module fetch_fifo
    import riscv_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t slot0;
    fetch_entry_t slot1;
    logic [1:0]   cnt;
    logic         pop_ok;
    logic         push_ok;

    // A pop needs something to remove; a push needs room after any pop.
    always_comb begin
        pop_ok  = pop && (cnt != 2'd0);
        push_ok = push && ((cnt != 2'd2) || pop_ok);
    end

    // Shift-register storage; flush wins over push and pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= 2'd0;
            slot0 <= EMPTY_ENTRY;
            slot1 <= EMPTY_ENTRY;
        end else if (flush) begin
            cnt   <= 2'd0;
            slot0 <= EMPTY_ENTRY;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (cnt == 2'd0) begin
                        slot0 <= push_data;
                    end else begin
                        slot1 <= push_data;
                    end
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    slot0 <= (cnt == 2'd2) ? slot1 : EMPTY_ENTRY;
                    cnt   <= cnt - 2'd1;
                end
                2'b11: begin
                    if (cnt == 2'd1) begin
                        slot0 <= push_data;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign count = cnt;
    assign head  = slot0;

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32I fetch stage: fetch PC, single outstanding imem request,
// two-entry result buffer and branch redirect handling.
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
);

    localparam word_t RESET_PC_W = word_align(RESET_PC);

    word_t        fetch_pc;
    word_t        req_pc;
    fetch_state_e state;
    logic         issue;
    logic         accept;
    logic         push;
    logic         pop;
    logic [1:0]   fifo_count;
    fetch_entry_t head;
    fetch_entry_t resp_entry;

    // Decide whether a new request may go out this cycle without overfilling the buffer.
    always_comb begin
        issue = 1'b0;
        case (state)
            IDLE:    issue = (fifo_count != 2'd2);
            WAIT:    issue = imem_rvalid &&
                             ((fifo_count == 2'd0) || ((fifo_count == 2'd1) && id_ready));
            DISCARD: issue = imem_rvalid;
            default: issue = 1'b0;
        endcase
    end

    // Request handshake and buffer control.
    always_comb begin
        imem_req   = issue && !rst && !redirect;
        accept     = imem_req && imem_ready;
        push       = (state == WAIT) && imem_rvalid && !redirect;
        pop        = id_valid && id_ready;
        resp_entry = '{pc: req_pc, instr: imem_rdata};
    end

    assign imem_addr = fetch_pc;

    // Fetch PC, in-flight PC and request FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC_W;
            req_pc   <= '0;
            state    <= IDLE;
        end else if (redirect) begin
            fetch_pc <= word_align(redirect_target);
            case (state)
                WAIT:    state <= imem_rvalid ? IDLE : DISCARD;
                DISCARD: state <= imem_rvalid ? IDLE : DISCARD;
                default: state <= IDLE;
            endcase
        end else if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + word_t'(4);
            state    <= WAIT;
        end else if (imem_rvalid && (state != IDLE)) begin
            state <= IDLE;
        end
    end

    fetch_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (resp_entry),
        .pop       (pop),
        .flush     (redirect),
        .count     (fifo_count),
        .head      (head)
    );

    // Decode-side view of the buffer head.
    always_comb begin
        id_valid    = (fifo_count != 2'd0);
        id_instr    = head.instr;
        id_pc       = head.pc;
        id_pc_plus4 = head.pc + word_t'(4);
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised scoreboard bench for instr_fetch_unit with a variable-latency memory model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0040;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    instr_fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .id_valid        (id_valid),
        .id_ready        (id_ready),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr + 32'h0000_0100;
    endfunction

    // ---------------- memory model: one request, response k cycles later ----
    int unsigned mem_k = 1;
    bit          mem_pending = 1'b0;
    int unsigned mem_rem = 0;
    logic [31:0] mem_addr_q = '0;
    int unsigned accept_cnt = 0;

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                mem_pending = 1'b0;
                imem_rvalid <= 1'b0;
            end else begin
                imem_rvalid <= 1'b0;
                if (imem_req && imem_ready) begin
                    check("single_inflight", 32'(mem_pending), 32'd0);
                    check("addr_align", imem_addr & 32'h3, 32'h0);
                    mem_pending = 1'b1;
                    mem_rem     = mem_k - 1;
                    mem_addr_q  = imem_addr;
                    accept_cnt++;
                end
                if (mem_pending) begin
                    if (mem_rem == 0) begin
                        imem_rvalid <= 1'b1;
                        imem_rdata  <= mem_word(mem_addr_q);
                        mem_pending = 1'b0;
                    end else begin
                        mem_rem--;
                    end
                end
            end
        end
    end

    // ---------------- reference model: expected fetch stream ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] fill_pc;
    int          consumed = 0;

    function automatic void refill();
        while (exp_q.size() < 8) begin
            exp_q.push_back('{pc: fill_pc, instr: mem_word(fill_pc)});
            fill_pc = fill_pc + 32'd4;
        end
    endfunction

    function automatic void restart(input logic [31:0] start);
        exp_q.delete();
        fill_pc = start;
        refill();
    endfunction

    // ---------------- monitor -----------------------------------------------
    bit          prev_rst    = 1'b0;
    bit          hold_pend   = 1'b0;
    logic [31:0] hold_addr   = '0;
    bit          redir_seen  = 1'b0;
    bit          tgt_pend    = 1'b0;
    logic [31:0] tgt_addr    = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (prev_rst) begin
                check("rst_imem_addr", imem_addr, RESET_PC);
                check("rst_id_valid", 32'(id_valid), 32'd0);
                check("rst_id_instr", id_instr, NOP);
                check("rst_id_pc", id_pc, 32'd0);
                check("rst_id_pc_plus4", id_pc_plus4, 32'd4);
            end
            if (rst) begin
                check("rst_imem_req", 32'(imem_req), 32'd0);
                restart(RESET_PC);
                hold_pend  = 1'b0;
                redir_seen = 1'b0;
                tgt_pend   = 1'b0;
            end else begin
                if (hold_pend && !redirect) begin
                    check("req_hold", 32'(imem_req), 32'd1);
                    check("addr_hold", imem_addr, hold_addr);
                end
                if (redir_seen) begin
                    check("redirect_flush", 32'(id_valid), 32'd0);
                    redir_seen = 1'b0;
                end
                if (tgt_pend && imem_req && !redirect) begin
                    check("redirect_addr", imem_addr, tgt_addr);
                    tgt_pend = 1'b0;
                end
                if (id_valid) begin
                    check("pc_plus4", id_pc_plus4, id_pc + 32'd4);
                end
                if (id_valid && id_ready) begin
                    e = exp_q.pop_front();
                    check("stream_pc", id_pc, e.pc);
                    check("stream_instr", id_instr, e.instr);
                    consumed++;
                    refill();
                end
                if (redirect) begin
                    tgt_addr = {redirect_target[31:2], 2'b00};
                    restart(tgt_addr);
                    redir_seen = 1'b1;
                    tgt_pend   = 1'b1;
                end
                hold_pend = imem_req && !imem_ready && !redirect;
                hold_addr = imem_addr;
            end
            prev_rst = rst;
        end
    end

    // ---------------- stimulus ----------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          first_valid;
        int          nvalid;
        int unsigned a0;
        bit          found;
        logic [31:0] seen_pc;

        rst             = 1'b1;
        imem_ready      = 1'b0;
        id_ready        = 1'b0;
        redirect        = 1'b0;
        redirect_target = '0;
        repeat (3) step();

        // Latency and back-to-back throughput with k=1.
        mem_k      = 1;
        imem_ready = 1'b1;
        id_ready   = 1'b1;
        rst        = 1'b0;
        first_valid = -1;
        nvalid      = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id_valid) begin
                if (first_valid < 0) first_valid = i;
                if (i >= 2) nvalid++;
            end
            step();
        end
        check("first_valid_cycle", 32'(first_valid), 32'd2);
        check("throughput", 32'(nvalid), 32'd28);

        // Decode stall fills the buffer and stops requests.
        id_ready = 1'b0;
        repeat (10) step();
        @(negedge clk);
        check("full_req_low", 32'(imem_req), 32'd0);
        check("full_id_valid", 32'(id_valid), 32'd1);
        step();
        id_ready = 1'b1;
        repeat (5) step();

        // Memory back-pressure: request held, then exactly one acceptance.
        imem_ready = 1'b0;
        a0 = accept_cnt;
        repeat (6) step();
        @(negedge clk);
        check("stall_req_high", 32'(imem_req), 32'd1);
        check("stall_no_accept", accept_cnt - a0, 32'd0);
        step();
        imem_ready = 1'b1;
        step();
        imem_ready = 1'b0;
        check("single_accept", accept_cnt - a0, 32'd1);
        step();
        imem_ready = 1'b1;
        repeat (5) step();

        // Redirect while a k=4 response is in flight.
        mem_k = 4;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (mem_pending && !imem_rvalid) found = 1'b1;
        end
        check("k4_inflight_found", 32'(found), 32'd1);
        redirect        = 1'b1;
        redirect_target = 32'h0000_0203;
        step();
        redirect = 1'b0;
        found    = 1'b0;
        seen_pc  = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (id_valid) begin
                found   = 1'b1;
                seen_pc = id_pc;
                break;
            end
        end
        check("k4_redirect_seen", 32'(found), 32'd1);
        check("k4_redirect_pc", seen_pc, 32'h0000_0200);
        repeat (5) step();

        // Redirect in the same cycle as a kept response.
        mem_k = 2;
        repeat (6) step();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (imem_rvalid) found = 1'b1;
        end
        check("rvalid_redirect_found", 32'(found), 32'd1);
        redirect        = 1'b1;
        redirect_target = 32'h0000_3a0e;
        step();
        redirect = 1'b0;
        repeat (10) step();

        // Random traffic with random latency, stalls and redirects.
        for (int i = 0; i < 500; i++) begin
            imem_ready      = ($urandom_range(0, 3) != 0);
            id_ready        = ($urandom_range(0, 9) < 7);
            mem_k           = $urandom_range(1, 4);
            redirect        = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom();
            step();
        end
        redirect = 1'b0;

        // Reset with a full buffer, then resume from RESET_PC.
        imem_ready = 1'b1;
        id_ready   = 1'b0;
        mem_k      = 1;
        repeat (8) step();
        @(negedge clk);
        check("pre_rst_full_req", 32'(imem_req), 32'd0);
        check("pre_rst_valid", 32'(id_valid), 32'd1);
        step();
        rst = 1'b1;
        repeat (2) step();
        rst      = 1'b0;
        id_ready = 1'b1;
        found    = 1'b0;
        seen_pc  = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (id_valid) begin
                found   = 1'b1;
                seen_pc = id_pc;
                break;
            end
        end
        check("resume_seen", 32'(found), 32'd1);
        check("resume_pc", seen_pc, RESET_PC);
        for (int i = 0; i < 40; i++) begin
            step();
            imem_ready = ($urandom_range(0, 2) != 0);
            mem_k      = $urandom_range(1, 3);
        end
        imem_ready = 1'b1;
        repeat (10) step();

        check("consumed_enough", 32'(consumed > 100), 32'd1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
